ps2_key_tracker: RTL

- Parametrised PS/2 scancode decoder. Sits downstream of the PS/2 port receiver and consumes its rx_done_tick/byte stream.
- Replaces the fixed eight-key decoder with:
  - a runtime-programmable key map of N_KEYS entries;
  - make/break and E0-extended prefix parsing;
  - a held-key state vector;
  - a buffered make/break event queue with a valid/ready handshake.

---
 rtl/ps2_key_tracker.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 scancode decoder: programmable key map, make/break + E0 prefix parsing,
// held-key vector and a buffered make/break event queue with valid/ready handshake.
module ps2_key_tracker #(
  parameter int N_KEYS     = 8,
  parameter int IDX_W      = 3,
  parameter int FIFO_DEPTH = 8,
  parameter bit REPEAT_EN  = 1'b0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_rx_done_tick,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_cfg_we,
  input  logic [IDX_W-1:0]              i_cfg_idx,
  input  logic [8:0]                    i_cfg_code,
  input  logic                          i_clr_all,
  input  logic                          i_evt_ready,
  output logic                          o_evt_valid,
  output logic [IDX_W:0]                o_evt_data,
  output logic [N_KEYS-1:0]             o_key_state,
  output logic                          o_any_key,
  output logic                          o_ovf,
  input  logic                          i_ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO  = (PTR_W+1)'(0);
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EXT     = 3'd1;
  localparam logic [2:0] ST_BRK     = 3'd2;
  localparam logic [2:0] ST_EXT_BRK = 3'd3;
  localparam logic [2:0] ST_SKIP    = 3'd4;

  // Keyboard status/ack bytes that carry no key information when seen between codes.
  function automatic logic f_is_status_byte(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: f_is_status_byte = 1'b1;
      default:                                  f_is_status_byte = 1'b0;
    endcase
  endfunction

  logic [2:0]             r_state;
  logic [2:0]             r_skip_cnt;
  logic [8:0]             r_map [N_KEYS];
  logic [N_KEYS-1:0]      r_key_state;
  logic [IDX_W:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_count;
  logic                   r_ovf;

  logic [2:0]             w_state_nxt;
  logic [2:0]             w_skip_nxt;
  logic                   w_code_vld;
  logic                   w_code_make;
  logic                   w_code_ext;
  logic                   w_hit;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_held;
  logic                   w_evt_push;
  logic                   w_pop;
  logic                   w_push_ok;
  logic                   w_drop;

  // Parser next state and completed-code decode.
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    w_code_vld  = 1'b0;
    w_code_make = 1'b0;
    w_code_ext  = 1'b0;
    if (i_rx_done_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (i_rx_data == 8'hE0) begin
            w_state_nxt = ST_EXT;
          end else if (i_rx_data == 8'hF0) begin
            w_state_nxt = ST_BRK;
          end else if (i_rx_data == 8'hE1) begin
            w_state_nxt = ST_SKIP;
            w_skip_nxt  = 3'd7;
          end else if (f_is_status_byte(i_rx_data)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_code_vld  = 1'b1;
            w_code_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (i_rx_data == 8'hF0) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (i_rx_data == 8'hE0) begin
            w_state_nxt = ST_EXT;
          end else begin
            w_code_vld  = 1'b1;
            w_code_make = 1'b1;
            w_code_ext  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_code_vld  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_code_vld  = 1'b1;
          w_code_ext  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_SKIP: begin
          w_skip_nxt = r_skip_cnt - 3'd1;
          if (r_skip_cnt == 3'd1) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_SKIP;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Key map lookup; scanning downward lets the lowest matching index win.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if ((r_map[i][7:0] != 8'h00) && (r_map[i] == {w_code_ext, i_rx_data})) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end else begin
        w_hit = w_hit;
      end
    end
  end

  assign w_held     = r_key_state[w_idx];
  assign w_evt_push = w_code_vld && w_hit && !i_clr_all &&
                      (w_code_make ? (!w_held || REPEAT_EN) : w_held);
  assign w_pop      = (r_count != CNT_ZERO) && i_evt_ready;
  assign w_push_ok  = w_evt_push && ((r_count < CNT_DEPTH) || w_pop);
  assign w_drop     = w_evt_push && !w_push_ok;

  // Parser state registers.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_skip_cnt <= 3'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_skip_cnt <= w_skip_nxt;
    end
  end

  // Key map storage; a write lands after this cycle's lookup.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < N_KEYS; i++) begin
        r_map[i] <= 9'h000;
      end
    end else if (i_cfg_we && (32'(i_cfg_idx) < N_KEYS)) begin
      r_map[i_cfg_idx] <= i_cfg_code;
    end else begin
      r_map <= r_map;
    end
  end

  // Held-key vector; key_state tracks every code even when its event is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_key_state <= '0;
    end else if (i_clr_all) begin
      r_key_state <= '0;
    end else if (w_code_vld && w_hit) begin
      r_key_state[w_idx] <= w_code_make;
    end else begin
      r_key_state <= r_key_state;
    end
  end

  // Event queue payload storage.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= {w_code_make, w_idx};
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Event queue pointers, occupancy and sticky overflow.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= CNT_ZERO;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end

  assign o_evt_valid  = (r_count != CNT_ZERO);
  assign o_evt_data   = r_mem[r_rd_ptr];
  assign o_key_state  = r_key_state;
  assign o_any_key    = |r_key_state;
  assign o_ovf        = r_ovf;
  assign o_fifo_count = r_count;

endmodule
